// File: rtl/ftc_tx_sched.sv
// rtl/ftc_tx_sched.sv - FTC 3b->4b transmit scheduler: word in, shield-separated encoded beats out
//
// Purpose: accepts a WORD_W-bit word on a valid/ready handshake, splits it into
// 3-bit groups (lowest first), encodes LANES groups per beat with the FTC
// codebook and presents the beats on a downstream valid/ready bus.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   in_data     raw word, sampled only on in_valid & in_ready
//   in_valid    in_data valid
//   in_ready    word accepted this cycle (combinational from state and bus_ready)
//   bus_data    lane j codeword at [5j+3:5j], shield bit at 5j+4 (always 0)
//   bus_valid   bus_data holds a valid beat
//   bus_ready   downstream consumes the beat this cycle
//   bus_last    current beat is the final beat of its word
//   words_done  count of fully transmitted words, wraps modulo 2^CNT_W

module ftc_tx_sched #(
    parameter int WORD_W = 12,
    parameter int LANES  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [5*LANES-2:0]   bus_data,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic                 bus_last,
    output logic [CNT_W-1:0]     words_done
);

    localparam int G     = WORD_W / 3;
    localparam int BEATS = G / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BUS_W = 5 * LANES - 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if (((WORD_W % (3 * LANES)) != 0) || (WORD_W < 3 * LANES)) begin : g_bad_word_w
        $error("ftc_tx_sched: WORD_W must be a nonzero multiple of 3*LANES");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [BUS_W-1:0]   data_q, data_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;

    function automatic logic [3:0] ftc_encode(input logic [2:0] g);
        logic [3:0] c;
        case (g)
            3'b000:  c = 4'b0000;
            3'b001:  c = 4'b0100;
            3'b010:  c = 4'b0001;
            3'b011:  c = 4'b0101;
            3'b100:  c = 4'b0111;
            3'b101:  c = 4'b1100;
            3'b110:  c = 4'b1101;
            default: c = 4'b1111;
        endcase
        return c;
    endfunction

    // Shield bits are left at the zero default; only the 4-bit lane fields are written.
    function automatic logic [BUS_W-1:0] beat_of(input logic [WORD_W-1:0] w,
                                                 input logic [BW-1:0]     k);
        logic [WORD_W-1:0] s;
        logic [BUS_W-1:0]  r;
        s = w >> (3 * LANES * int'(k));
        r = '0;
        for (int j = 0; j < LANES; j++) begin
            r[5*j +: 4] = ftc_encode(s[3*j +: 3]);
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        word_d   = word_q;
        data_d   = data_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        accept   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            SEND: begin
                if (bus_ready) begin
                    if (last_q) begin
                        cnt_d    = cnt_q + CNT_W'(1);
                        in_ready = 1'b1;
                        accept   = in_valid;
                        if (!in_valid) begin
                            state_d = IDLE;
                            last_d  = 1'b0;
                        end
                    end else begin
                        beat_d = beat_q + BW'(1);
                        data_d = beat_of(word_q, beat_q + BW'(1));
                        last_d = ((beat_q + BW'(1)) == LAST_BEAT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // New word (from IDLE or back-to-back after a last beat): beat 0 next cycle.
        if (accept) begin
            state_d = SEND;
            word_d  = in_data;
            beat_d  = '0;
            data_d  = beat_of(in_data, '0);
            last_d  = (BEATS == 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            word_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            word_q  <= word_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_data   = data_q;
    assign bus_valid  = (state_q == SEND);
    assign bus_last   = last_q;
    assign words_done = cnt_q;

endmodule
